// File: rtl/video_stream_rx_monitor.sv
// video_stream_rx_monitor
//   In-line receive monitor for the 8-bit vsync/hsync/valid/data video stream.
//   Measures the resolution of each frame, checks that every line has the
//   same width as the first one, flags valid pixels seen during vsync and
//   raises stream_lost when no frame start arrives for TIMEOUT_CYC clocks.
//
//   Optional feature macro: VSTREAM_RX_CHECKSUM_EN
//     defined   -> frame_sum carries the modulo-2^32 sum of pixel data per frame
//     undefined -> no accumulator, frame_sum is tied to zero
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   vin_vsync         frame sync, rising edge starts a frame
//   vin_hsync         line sync, ignored (lines are delimited by valid runs)
//   vin_valid         active pixel qualifier
//   vin_dat[7:0]      pixel data
//   meas_xres[15:0]   width of the first line of the last completed frame
//   meas_yres[15:0]   line count of the last completed frame
//   frame_done        one-clock pulse when the results above are updated
//   frame_err[3:0]    {valid in vsync, Y mismatch, X mismatch, line width varies}
//   frame_cnt[15:0]   completed frames (wrapping)
//   stream_lost       level, no frame start for TIMEOUT_CYC clocks
//   frame_sum[31:0]   data checksum of the last completed frame
module video_stream_rx_monitor #(
  parameter logic [15:0] EXP_XRES    = 16'd0,
  parameter logic [15:0] EXP_YRES    = 16'd0,
  parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vin_vsync,
  input  logic        vin_hsync,
  input  logic        vin_valid,
  input  logic [7:0]  vin_dat,
  output logic [15:0] meas_xres,
  output logic [15:0] meas_yres,
  output logic        frame_done,
  output logic [3:0]  frame_err,
  output logic [15:0] frame_cnt,
  output logic        stream_lost,
  output logic [31:0] frame_sum
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic        vsync_d, valid_d;
  logic        vs_rise, line_end;
  logic        frame_close, frame_start;

  logic [15:0] pix_cnt, line_cnt, ref_w;
  logic        wk_err0, wk_err3;
  logic [31:0] wd_cnt, wd_inc;

  // Values the closing frame would hold after this edge, so a line ending on
  // the same edge as the vsync rise is still counted into that frame.
  logic        first_line;
  logic [15:0] line_cnt_inc, line_cnt_close, ref_w_close;
  logic        width_mismatch, err0_close;

  assign vs_rise  = vin_vsync & ~vsync_d;
  assign line_end = valid_d & ~vin_valid;

  assign first_line     = (line_cnt == 16'd0);
  assign line_cnt_inc   = (line_cnt == 16'hFFFF) ? line_cnt : line_cnt + 16'd1;
  assign line_cnt_close = line_end ? line_cnt_inc : line_cnt;
  assign ref_w_close    = (line_end && first_line) ? pix_cnt : ref_w;
  assign width_mismatch = line_end && !first_line && (pix_cnt != ref_w);
  assign err0_close     = wk_err0 | width_mismatch;

  assign wd_inc = (wd_cnt == 32'hFFFF_FFFF) ? wd_cnt : wd_cnt + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A vsync rise while the stream is flagged lost restarts like a first frame.
  always_comb begin
    state_next  = state;
    frame_close = 1'b0;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (vs_rise) begin
          frame_start = 1'b1;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (vs_rise) begin
          if (stream_lost) frame_start = 1'b1;
          else             frame_close = 1'b1;
        end else if (stream_lost) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      valid_d <= 1'b0;
    end else begin
      vsync_d <= vin_vsync;
      valid_d <= vin_valid;
    end
  end

  // Working counters. A new frame begins on the vsync-rise edge itself, so a
  // valid sample on that edge already belongs to (and errors) the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt  <= 16'd0;
      line_cnt <= 16'd0;
      ref_w    <= 16'd0;
      wk_err0  <= 1'b0;
      wk_err3  <= 1'b0;
    end else if (frame_close || frame_start) begin
      pix_cnt  <= {15'd0, vin_valid};
      line_cnt <= 16'd0;
      ref_w    <= 16'd0;
      wk_err0  <= 1'b0;
      wk_err3  <= vin_valid;
    end else if (state == RUN) begin
      if (line_end) begin
        line_cnt <= line_cnt_inc;
        ref_w    <= ref_w_close;
        wk_err0  <= err0_close;
        pix_cnt  <= 16'd0;
      end else if (vin_valid && pix_cnt != 16'hFFFF) begin
        pix_cnt <= pix_cnt + 16'd1;
      end
      if (vin_valid && vin_vsync) wk_err3 <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_xres  <= 16'd0;
      meas_yres  <= 16'd0;
      frame_done <= 1'b0;
      frame_err  <= 4'd0;
      frame_cnt  <= 16'd0;
    end else begin
      frame_done <= frame_close;
      if (frame_close) begin
        meas_xres    <= ref_w_close;
        meas_yres    <= line_cnt_close;
        frame_err[0] <= err0_close;
        frame_err[1] <= (EXP_XRES != 16'd0) && (ref_w_close != EXP_XRES);
        frame_err[2] <= (EXP_YRES != 16'd0) && (line_cnt_close != EXP_YRES);
        frame_err[3] <= wk_err3;
        frame_cnt    <= frame_cnt + 16'd1;
      end
    end
  end

  // Watchdog: counts clocks since the last vsync rise, independent of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= 32'd0;
      stream_lost <= 1'b0;
    end else if (vs_rise) begin
      wd_cnt      <= 32'd0;
      stream_lost <= 1'b0;
    end else begin
      wd_cnt <= wd_inc;
      if (wd_inc >= TIMEOUT_CYC) stream_lost <= 1'b1;
    end
  end

`ifdef VSTREAM_RX_CHECKSUM_EN
  logic [31:0] sum_acc;
  logic        unused_hsync;
  assign unused_hsync = vin_hsync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_acc   <= 32'd0;
      frame_sum <= 32'd0;
    end else begin
      if (frame_close) frame_sum <= sum_acc;
      if (frame_close || frame_start)
        sum_acc <= vin_valid ? {24'd0, vin_dat} : 32'd0;
      else if (state == RUN && vin_valid)
        sum_acc <= sum_acc + {24'd0, vin_dat};
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = vin_hsync ^ (^vin_dat);
  assign frame_sum     = 32'd0;
`endif

endmodule

// File: tb/tb_video_stream_rx_monitor.sv
// Self-checking bench for video_stream_rx_monitor. Builds frames from line
// widths, tracks valid runs per frame in a queue and derives the expected
// frame results from them; every cycle all outputs are compared.
module tb_video_stream_rx_monitor;
  localparam int EXP_X = 8;
  localparam int EXP_Y = 4;
  localparam int TO    = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vin_vsync = 1'b0, vin_hsync = 1'b0, vin_valid = 1'b0;
  logic [7:0]  vin_dat = 8'd0;
  logic [15:0] meas_xres, meas_yres, frame_cnt;
  logic        frame_done, stream_lost;
  logic [3:0]  frame_err;
  logic [31:0] frame_sum;

  int checks = 0;
  int failures = 0;

  // reference model state
  int          q[$];
  int          m_run, m_since;
  bit          m_running, m_lost, m_err3, m_prev_vs, m_prev_va, m_done;
  logic [31:0] m_sum, m_fsum;
  logic [15:0] m_x, m_y, m_cnt;
  logic [3:0]  m_err;

  video_stream_rx_monitor #(
    .EXP_XRES(16'(EXP_X)), .EXP_YRES(16'(EXP_Y)), .TIMEOUT_CYC(32'(TO))
  ) dut (
    .clk(clk), .rst_n(rst_n), .vin_vsync(vin_vsync), .vin_hsync(vin_hsync),
    .vin_valid(vin_valid), .vin_dat(vin_dat), .meas_xres(meas_xres),
    .meas_yres(meas_yres), .frame_done(frame_done), .frame_err(frame_err),
    .frame_cnt(frame_cnt), .stream_lost(stream_lost), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef VSTREAM_RX_CHECKSUM_EN
    return s;
`else
    return 32'd0 & s;
`endif
  endfunction

  task automatic model_clear();
    q.delete();
    m_run = 0; m_since = 0; m_running = 0; m_lost = 0; m_err3 = 0;
    m_prev_vs = 0; m_prev_va = 0; m_done = 0; m_sum = 0; m_fsum = 0;
    m_x = 0; m_y = 0; m_cnt = 0; m_err = 0;
  endtask

  task automatic check_all();
    check("frame_done", {31'd0, frame_done}, {31'd0, m_done});
    check("stream_lost", {31'd0, stream_lost}, {31'd0, m_lost});
    check("meas_xres", {16'd0, meas_xres}, {16'd0, m_x});
    check("meas_yres", {16'd0, meas_yres}, {16'd0, m_y});
    check("frame_err", {28'd0, frame_err}, {28'd0, m_err});
    check("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
    check("frame_sum", frame_sum, exp_sum(m_fsum));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; vin_vsync = 0; vin_valid = 0; vin_dat = 0;
    #1;
    model_clear();
    check_all();
    @(posedge clk); @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;
  endtask

  // One clock of stimulus; the model advances by the same sample.
  task automatic drive(input logic vs, input logic va, input logic [7:0] d);
    bit rise, e0, e1, e2;
    int lines;
    rise = vs && !m_prev_vs;
    m_done = 0;
    if (rise) begin
      if (m_running && !m_lost) begin
        lines = q.size();
        m_x = (lines > 0) ? 16'(q[0]) : 16'd0;
        m_y = 16'(lines);
        e0 = 0;
        foreach (q[i]) if (q[i] != q[0]) e0 = 1;
        e1 = (EXP_X != 0) && (int'(m_x) != EXP_X);
        e2 = (EXP_Y != 0) && (lines != EXP_Y);
        m_err = {m_err3, e2, e1, e0};
        m_fsum = m_sum;
        m_cnt = m_cnt + 16'd1;
        m_done = 1;
      end
      q.delete(); m_run = 0; m_err3 = 0; m_sum = 0;
      m_running = 1; m_since = 0; m_lost = 0;
    end else begin
      m_since++;
      if (m_since >= TO) begin m_lost = 1; m_running = 0; end
      if (m_running) begin
        if (va) begin
          m_run++; m_sum += {24'd0, d};
          if (vs) m_err3 = 1;
        end else if (m_prev_va) begin
          q.push_back(m_run); m_run = 0;
        end
      end
    end
    m_prev_vs = vs; m_prev_va = va;
    vin_vsync = vs; vin_valid = va; vin_dat = d;
    vin_hsync = va ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    check_all();
  endtask

  // vsync pulse, porch, then h lines of width w (line short_idx one shorter).
  task automatic gen_frame(input int w, input int h, input int short_idx,
                           input bit inject, input bit seq);
    logic [7:0] d;
    d = 8'd1;
    drive(1, 0, 0);
    drive(1, inject, 8'hA5);
    drive(0, 0, 0);
    drive(0, 0, 0);
    for (int l = 0; l < h; l++) begin
      int lw, nb;
      lw = (l == short_idx) ? w - 1 : w;
      for (int p = 0; p < lw; p++) begin
        drive(0, 1, seq ? d : 8'($urandom));
        d = d + 8'd1;
      end
      nb = int'($urandom_range(1, 3));
      for (int b = 0; b < nb; b++) drive(0, 0, 0);
    end
  endtask

  initial begin
    model_clear();
    do_reset();

    // clean 8x4 frames: first start gives no result, second close does
    gen_frame(8, 4, -1, 0, 0);
    gen_frame(8, 4, -1, 0, 0);
    check("xres_8x4", {16'd0, meas_xres}, 32'd8);
    check("yres_8x4", {16'd0, meas_yres}, 32'd4);
    check("err_clean", {28'd0, frame_err}, 32'd0);
    check("cnt_first", {16'd0, frame_cnt}, 32'd1);

    // line 3 shortened
    gen_frame(8, 4, 2, 0, 0);
    gen_frame(8, 4, -1, 0, 0);
    check("err_short", {28'd0, frame_err}, 32'd1);

    // resolution mismatch in both axes
    gen_frame(10, 5, -1, 0, 0);
    gen_frame(8, 4, -1, 0, 0);
    check("err_res", {28'd0, frame_err}, 32'd6);
    check("xres_10", {16'd0, meas_xres}, 32'd10);

    // valid during vsync
    gen_frame(8, 4, -1, 1, 0);
    gen_frame(8, 4, -1, 0, 0);
    check("err_vsync", {31'd0, frame_err[3]}, 32'd1);

    // checksum of 4x2 frame with data 1..8
    gen_frame(4, 2, -1, 0, 1);
    gen_frame(8, 4, -1, 0, 0);
    check("sum_4x2", frame_sum, exp_sum(32'd36));

    // randomized frames, including zero-line frames
    for (int f = 0; f < 24; f++) begin
      int w, h, s;
      w = int'($urandom_range(6, 10));
      h = int'($urandom_range(0, 5));
      s = (h > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, h - 1)) : -1;
      gen_frame(w, h, s, $urandom_range(0, 4) == 0, 0);
    end

    // loss of stream, then recovery
    for (int i = 0; i < 150; i++) drive(0, 0, 0);
    check("lost_set", {31'd0, stream_lost}, 32'd1);
    gen_frame(8, 4, -1, 0, 0);
    check("lost_clear", {31'd0, stream_lost}, 32'd0);
    gen_frame(8, 4, -1, 0, 0);
    gen_frame(8, 4, -1, 0, 0);

    // reset in the middle of a frame
    drive(1, 0, 0);
    drive(0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 8'($urandom));
    drive(0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 8'($urandom));
    do_reset();
    gen_frame(8, 4, -1, 0, 0);
    gen_frame(8, 4, -1, 0, 0);
    check("cnt_after_rst", {16'd0, frame_cnt}, 32'd1);
    gen_frame(0, 0, -1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
